// File: rtl/bios_uart_arb_pkg.sv
// bios_uart_arb_pkg: shared states, grant ids and ASCII constants for the BIOS/CPU UART arbiter
package bios_uart_arb_pkg;
  typedef enum logic [1:0] {ST_BOOT, ST_DRAIN, ST_RUN} state_e;
  typedef enum logic {GNT_BIOS, GNT_CPU} gnt_e;
  localparam logic [7:0] ASCII_ESC = 8'h1B;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ESC_CHAR_DEF = ASCII_ESC;
endpackage

// File: rtl/bios_tx_rr_mux.sv
// bios_tx_rr_mux: round-robin BIOS/CPU merge into a single-entry UART transmit register
module bios_tx_rr_mux
  import bios_uart_arb_pkg::*;
(
  input  logic       clk,
  input  logic       clk_en,
  input  logic       rst,
  input  logic       cpu_en,
  input  logic [7:0] bios_tx_data,
  input  logic       bios_tx_valid,
  output logic       bios_tx_ready,
  input  logic [7:0] cpu_tx_data,
  input  logic       cpu_tx_valid,
  output logic       cpu_tx_ready,
  output logic [7:0] uart_tx_data,
  output logic       uart_tx_valid,
  input  logic       uart_tx_ready
);
  logic [7:0] tx_q, tx_d;
  logic tx_valid_q, tx_valid_d;
  gnt_e last_grant_q, last_grant_d, gnt;
  logic cpu_v, load_ok, load;
  always_comb begin
    cpu_v = cpu_en && cpu_tx_valid;
    gnt = (bios_tx_valid && cpu_v) ? (last_grant_q == GNT_BIOS ? GNT_CPU : GNT_BIOS) : (cpu_v ? GNT_CPU : GNT_BIOS);
    load_ok = clk_en && (!tx_valid_q || uart_tx_ready);
    bios_tx_ready = load_ok && gnt == GNT_BIOS;
    cpu_tx_ready = load_ok && gnt == GNT_CPU;
    load = (bios_tx_ready && bios_tx_valid) || (cpu_tx_ready && cpu_tx_valid);
    tx_d = load ? (gnt == GNT_CPU ? cpu_tx_data : bios_tx_data) : tx_q;
    tx_valid_d = load || (tx_valid_q && !(clk_en && uart_tx_ready));
    last_grant_d = load ? gnt : last_grant_q;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_q <= 8'h00;
      tx_valid_q <= 1'b0;
      last_grant_q <= GNT_CPU;
    end else begin
      tx_q <= tx_d;
      tx_valid_q <= tx_valid_d;
      last_grant_q <= last_grant_d;
    end
  end
  assign uart_tx_data = tx_q;
  assign uart_tx_valid = tx_valid_q;
endmodule

// File: rtl/bios_uart_arb.sv
// bios_uart_arb: routes one UART between BIOS and CPU, switching BOOT->RUN on boot_req and back on an escape sequence
module bios_uart_arb
  import bios_uart_arb_pkg::*;
#(
  parameter logic [7:0] ESC_CHAR = ESC_CHAR_DEF,
  parameter int ESC_COUNT = 3
) (
  input  logic       clk,
  input  logic       clk_en,
  input  logic       rst,
  input  logic [7:0] uart_rx_data,
  input  logic       uart_rx_valid,
  output logic       uart_rx_ready,
  output logic [7:0] uart_tx_data,
  output logic       uart_tx_valid,
  input  logic       uart_tx_ready,
  output logic [7:0] bios_rx_data,
  output logic       bios_rx_valid,
  input  logic       bios_rx_ready,
  input  logic [7:0] bios_tx_data,
  input  logic       bios_tx_valid,
  output logic       bios_tx_ready,
  input  logic       boot_req,
  output logic [7:0] cpu_rx_data,
  output logic       cpu_rx_valid,
  input  logic       cpu_rx_ready,
  input  logic [7:0] cpu_tx_data,
  input  logic       cpu_tx_valid,
  output logic       cpu_tx_ready,
  output logic       cpu_hold,
  output logic       run_mode
);
  localparam int CW = $clog2(ESC_COUNT + 1);
  localparam logic [CW-1:0] ESC_MAX = CW'(ESC_COUNT);
  state_e state_q, state_d;
  logic run_q, run_d;
  logic [CW-1:0] esc_cnt_q, esc_cnt_d, esc_inc;
  logic rx_acc, esc_hit;
  always_comb begin
    bios_rx_data = uart_rx_data;
    cpu_rx_data = uart_rx_data;
    bios_rx_valid = uart_rx_valid && state_q == ST_BOOT;
    cpu_rx_valid = uart_rx_valid && state_q == ST_RUN;
    uart_rx_ready = clk_en && (state_q == ST_BOOT ? bios_rx_ready : state_q == ST_RUN && cpu_rx_ready);
    rx_acc = uart_rx_valid && uart_rx_ready;
    esc_inc = esc_cnt_q == ESC_MAX ? ESC_MAX : esc_cnt_q + 1'b1;
    esc_hit = state_q == ST_RUN && rx_acc && uart_rx_data == ESC_CHAR && esc_inc == ESC_MAX;
    state_d = !clk_en ? state_q :
              state_q == ST_BOOT ? (boot_req ? ST_DRAIN : ST_BOOT) :
              state_q == ST_DRAIN ? (!uart_tx_valid && !bios_tx_valid ? ST_RUN : ST_DRAIN) :
              state_q == ST_RUN ? (esc_hit ? ST_BOOT : ST_RUN) : ST_BOOT;
    esc_cnt_d = state_q != ST_RUN ? '0 : !rx_acc ? esc_cnt_q : uart_rx_data == ESC_CHAR ? esc_inc : '0;
    run_d = state_d == ST_RUN;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_BOOT;
      run_q <= 1'b0;
      esc_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      run_q <= run_d;
      esc_cnt_q <= esc_cnt_d;
    end
  end
  assign run_mode = run_q;
  assign cpu_hold = !run_q;
  bios_tx_rr_mux u_tx (
    .clk(clk),
    .clk_en(clk_en),
    .rst(rst),
    .cpu_en(state_q == ST_RUN),
    .bios_tx_data(bios_tx_data),
    .bios_tx_valid(bios_tx_valid),
    .bios_tx_ready(bios_tx_ready),
    .cpu_tx_data(cpu_tx_data),
    .cpu_tx_valid(cpu_tx_valid),
    .cpu_tx_ready(cpu_tx_ready),
    .uart_tx_data(uart_tx_data),
    .uart_tx_valid(uart_tx_valid),
    .uart_tx_ready(uart_tx_ready)
  );
endmodule

// File: tb/tb_bios_uart_arb.sv
// tb_bios_uart_arb: directed self-checking bench for bios_uart_arb
module tb_bios_uart_arb;
  logic clk = 1'b0;
  logic clk_en, rst;
  logic [7:0] uart_rx_data, uart_tx_data, bios_rx_data, bios_tx_data, cpu_rx_data, cpu_tx_data;
  logic uart_rx_valid, uart_rx_ready, uart_tx_valid, uart_tx_ready;
  logic bios_rx_valid, bios_rx_ready, bios_tx_valid, bios_tx_ready, boot_req;
  logic cpu_rx_valid, cpu_rx_ready, cpu_tx_valid, cpu_tx_ready, cpu_hold, run_mode;
  int checks = 0;
  int failures = 0;
  logic [7:0] nop_b [3] = '{8'h6E, 8'h6F, 8'h70};
  logic [7:0] esc_b [6] = '{8'h1B, 8'h1B, 8'h41, 8'h1B, 8'h1B, 8'h1B};
  logic [7:0] abc_b [3] = '{8'h61, 8'h62, 8'h63};
  int idx;
  always #5 clk = ~clk;
  bios_uart_arb dut (
    .clk(clk), .clk_en(clk_en), .rst(rst),
    .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid), .uart_rx_ready(uart_rx_ready),
    .uart_tx_data(uart_tx_data), .uart_tx_valid(uart_tx_valid), .uart_tx_ready(uart_tx_ready),
    .bios_rx_data(bios_rx_data), .bios_rx_valid(bios_rx_valid), .bios_rx_ready(bios_rx_ready),
    .bios_tx_data(bios_tx_data), .bios_tx_valid(bios_tx_valid), .bios_tx_ready(bios_tx_ready),
    .boot_req(boot_req),
    .cpu_rx_data(cpu_rx_data), .cpu_rx_valid(cpu_rx_valid), .cpu_rx_ready(cpu_rx_ready),
    .cpu_tx_data(cpu_tx_data), .cpu_tx_valid(cpu_tx_valid), .cpu_tx_ready(cpu_tx_ready),
    .cpu_hold(cpu_hold), .run_mode(run_mode)
  );
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    clk_en = 1; rst = 0;
    uart_rx_data = 0; uart_rx_valid = 0; uart_tx_ready = 0;
    bios_rx_ready = 0; bios_tx_data = 0; bios_tx_valid = 0; boot_req = 0;
    cpu_rx_ready = 0; cpu_tx_data = 0; cpu_tx_valid = 0;
    tick; tick;
    chk("rst_run_mode", run_mode, 0);
    chk("rst_cpu_hold", cpu_hold, 1);
    chk("rst_tx_valid", uart_tx_valid, 0);
    chk("rst_tx_data", uart_tx_data, 8'h00);
    rst = 1; bios_rx_ready = 1;
    for (int i = 0; i < 3; i++) begin
      uart_rx_data = nop_b[i]; uart_rx_valid = 1; #1;
      chk("boot_bios_rx_valid", bios_rx_valid, 1);
      chk("boot_bios_rx_data", bios_rx_data, nop_b[i]);
      chk("boot_cpu_rx_valid", cpu_rx_valid, 0);
      chk("boot_rx_ready", uart_rx_ready, 1);
      tick;
    end
    uart_rx_valid = 0;
    chk("boot_cpu_hold", cpu_hold, 1);
    chk("boot_run_mode", run_mode, 0);
    bios_tx_data = 8'h42; bios_tx_valid = 1; boot_req = 1; uart_tx_ready = 0; #1;
    chk("drain_bios_tx_ready", bios_tx_ready, 1);
    tick;
    bios_tx_valid = 0; boot_req = 0;
    chk("drain_tx_valid", uart_tx_valid, 1);
    chk("drain_tx_data", uart_tx_data, 8'h42);
    uart_rx_valid = 1; uart_rx_data = 8'h78; #1;
    chk("drain_rx_ready", uart_rx_ready, 0);
    chk("drain_bios_rx_valid", bios_rx_valid, 0);
    chk("drain_cpu_rx_valid", cpu_rx_valid, 0);
    uart_rx_valid = 0;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("drain_hold_run", run_mode, 0);
      chk("drain_hold_txv", uart_tx_valid, 1);
    end
    uart_tx_ready = 1;
    tick;
    chk("drain_accept_txv", uart_tx_valid, 0);
    chk("drain_accept_run", run_mode, 0);
    tick;
    chk("run_entry_mode", run_mode, 1);
    chk("run_entry_hold", cpu_hold, 0);
    boot_req = 1;
    tick;
    boot_req = 0;
    chk("run_ignore_boot_req", run_mode, 1);
    cpu_tx_data = 8'hC5; cpu_tx_valid = 1; #1;
    chk("run_cpu_only_ready", cpu_tx_ready, 1);
    chk("run_cpu_only_bios_ready", bios_tx_ready, 0);
    tick;
    chk("run_cpu_only_data", uart_tx_data, 8'hC5);
    chk("run_cpu_only_valid", uart_tx_valid, 1);
    bios_tx_data = 8'hB0; bios_tx_valid = 1; cpu_tx_data = 8'hC0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_bios_ready", bios_tx_ready, (i % 2 == 0));
      chk("rr_cpu_ready", cpu_tx_ready, (i % 2 == 1));
      tick;
      chk("rr_data", uart_tx_data, (i % 2 == 0) ? 8'hB0 : 8'hC0);
      chk("rr_valid", uart_tx_valid, 1);
    end
    bios_tx_valid = 0; cpu_tx_valid = 0;
    tick;
    chk("rr_drain_valid", uart_tx_valid, 0);
    cpu_rx_ready = 1; uart_tx_ready = 0;
    for (int i = 0; i < 6; i++) begin
      uart_rx_data = esc_b[i]; uart_rx_valid = 1;
      if (i == 5) begin
        cpu_tx_data = 8'hCC; cpu_tx_valid = 1;
      end
      #1;
      chk("esc_cpu_rx_valid", cpu_rx_valid, 1);
      chk("esc_cpu_rx_data", cpu_rx_data, esc_b[i]);
      chk("esc_rx_ready", uart_rx_ready, 1);
      chk("esc_bios_rx_valid", bios_rx_valid, 0);
      if (i == 5) chk("esc_final_cpu_tx_ready", cpu_tx_ready, 1);
      tick;
      chk("esc_run_mode", run_mode, (i < 5));
    end
    uart_rx_valid = 0;
    chk("esc_boot_hold", cpu_hold, 1);
    chk("esc_cpu_byte_valid", uart_tx_valid, 1);
    chk("esc_cpu_byte_data", uart_tx_data, 8'hCC);
    #1;
    chk("boot_cpu_tx_ready", cpu_tx_ready, 0);
    tick;
    cpu_tx_valid = 0;
    chk("boot_cpu_byte_held_v", uart_tx_valid, 1);
    chk("boot_cpu_byte_held_d", uart_tx_data, 8'hCC);
    uart_tx_ready = 1;
    tick;
    chk("boot_cpu_byte_drained", uart_tx_valid, 0);
    chk("boot_still_boot", run_mode, 0);
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      clk_en = (c % 2 == 0);
      uart_rx_data = abc_b[idx]; uart_rx_valid = 1; #1;
      chk("cen_rx_ready", uart_rx_ready, clk_en);
      chk("cen_bios_tx_ready", bios_tx_ready, clk_en);
      chk("cen_rx_order", bios_rx_data, abc_b[idx]);
      tick;
      if (clk_en) idx++;
    end
    uart_rx_valid = 0; clk_en = 1;
    bios_tx_data = 8'h78; bios_tx_valid = 1; #1;
    chk("cen_tx_ready_x", bios_tx_ready, 1);
    tick;
    chk("cen_tx_data_x", uart_tx_data, 8'h78);
    bios_tx_data = 8'h79; clk_en = 0; #1;
    chk("cen_tx_ready_off", bios_tx_ready, 0);
    tick;
    chk("cen_tx_hold_data", uart_tx_data, 8'h78);
    chk("cen_tx_hold_valid", uart_tx_valid, 1);
    clk_en = 1; #1;
    chk("cen_tx_ready_y", bios_tx_ready, 1);
    tick;
    chk("cen_tx_data_y", uart_tx_data, 8'h79);
    bios_tx_valid = 0; clk_en = 0;
    tick;
    chk("cen_tx_hold_y_valid", uart_tx_valid, 1);
    chk("cen_tx_hold_y_data", uart_tx_data, 8'h79);
    clk_en = 1;
    tick;
    chk("cen_tx_drained", uart_tx_valid, 0);
    uart_tx_ready = 0; bios_tx_data = 8'h5A; bios_tx_valid = 1; boot_req = 1;
    tick;
    bios_tx_valid = 0; boot_req = 0;
    chk("mid_rst_loaded_v", uart_tx_valid, 1);
    chk("mid_rst_loaded_d", uart_tx_data, 8'h5A);
    rst = 0; clk_en = 0;
    tick;
    chk("mid_rst_tx_valid", uart_tx_valid, 0);
    chk("mid_rst_tx_data", uart_tx_data, 8'h00);
    chk("mid_rst_run_mode", run_mode, 0);
    chk("mid_rst_cpu_hold", cpu_hold, 1);
    rst = 1; clk_en = 1; uart_tx_ready = 1;
    tick;
    chk("post_rst_tx_valid", uart_tx_valid, 0);
    chk("post_rst_state_boot", run_mode, 0);
    uart_rx_data = 8'h33; uart_rx_valid = 1; #1;
    chk("post_rst_bios_route", bios_rx_valid, 1);
    uart_rx_valid = 0;
    boot_req = 1;
    tick;
    boot_req = 0;
    tick;
    chk("post_rst_run", run_mode, 1);
    bios_tx_valid = 1; cpu_tx_valid = 1; #1;
    chk("post_rst_first_bios", bios_tx_ready, 1);
    chk("post_rst_first_cpu", cpu_tx_ready, 0);
    bios_tx_valid = 0; cpu_tx_valid = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bios_uart_arb.md
BIOS_UART_ARB -- requirements
Module: bios_uart_arb

Interface
REQ-001 The block SHALL have parameter ESC_CHAR, default 8'h1B, the escape byte that returns the link from RUN to BOOT.
REQ-002 The block SHALL have parameter ESC_COUNT, default 3, the number of consecutive ESC_CHAR bytes that trigger the return.
REQ-003 The block SHALL have one clock and a synchronous, active-low reset:
- clk  in  1  system clock.
- clk_en  in  1  global clock enable; all state updates qualified by it.
- rst  in  1  synchronous active-low reset.
REQ-004 UART side ports SHALL be:
- uart_rx_data  in  8  received byte.
- uart_rx_valid  in  1  received byte valid.
- uart_rx_ready  out  1  received byte accepted.
- uart_tx_data  out  8  byte to transmit.
- uart_tx_valid  out  1  transmit byte valid.
- uart_tx_ready  in  1  transmitter accepts byte.
REQ-005 BIOS side ports SHALL be:
- bios_rx_data/valid  out  8/1  command stream to the BIOS.
- bios_rx_ready  in  1  BIOS accepts byte.
- bios_tx_data/valid  in  8/1  BIOS response byte.
- bios_tx_ready  out  1  response accepted.
- boot_req  in  1  one-cycle pulse; "boot" command completed.
REQ-006 CPU side ports SHALL be:
- cpu_rx_data/valid  out  8/1  console input to CPU GPIO.
- cpu_rx_ready  in  1  CPU accepts byte.
- cpu_tx_data/valid  in  8/1  console output from CPU.
- cpu_tx_ready  out  1  CPU byte accepted.
- cpu_hold  out  1  holds CPU in reset while not in RUN.
- run_mode  out  1  1 = RUN state.

Function
REQ-007 The FSM SHALL have the states ST_BOOT, ST_DRAIN and ST_RUN; a handshake SHALL complete only in cycles where clk_en=1, and every ready output SHALL be 0 when clk_en=0.
REQ-008 ST_BOOT transitions:
- boot_req=1 (with clk_en) -> ST_DRAIN.
- boot_req=0 -> remain in ST_BOOT.
REQ-009 ST_DRAIN SHALL move to ST_RUN in the first clk_en cycle where uart_tx_valid=0 and bios_tx_valid=0.
REQ-010 ST_RUN SHALL move to ST_BOOT on the accepted uart_rx byte that brings esc_cnt to ESC_COUNT.
REQ-011 esc_cnt behaviour:
- increments on each accepted ESC_CHAR byte in ST_RUN.
- clears on any other accepted byte and on every entry to ST_RUN.
- saturates at ESC_COUNT.
REQ-012 RX routing SHALL be combinational with zero latency:
- ST_BOOT: uart_rx maps to bios_rx.
- ST_RUN: uart_rx maps to cpu_rx.
- ST_DRAIN: uart_rx_ready=0 and both *_rx_valid=0.
- The non-selected *_rx_valid SHALL be 0.
REQ-013 The escape bytes, including the final one, SHALL be forwarded to the CPU like any other byte.
REQ-014 TX SHALL pass through a single-entry output register (tx_q, tx_valid_q).
- load_ok = !tx_valid_q || uart_tx_ready.
- A granted source handshake loads tx_q; uart_tx_valid rises the next cycle (1-cycle latency).
- Back-to-back throughput is 1 byte/cycle.
REQ-015 Grant rules:
- ST_BOOT/ST_DRAIN: only BIOS is eligible; cpu_tx_ready=0.
- ST_RUN: if one source is valid, it is granted.
- ST_RUN: if both are valid, the source not granted last (last_grant) wins; last_grant updates on each load.
REQ-016 bios_tx_ready SHALL be high only in a clk_en cycle where load_ok=1 and BIOS is granted; cpu_tx_ready likewise for CPU.
REQ-017 A byte held in tx_q SHALL NOT be dropped or altered until uart_tx_ready is seen with clk_en, including across a RUN->BOOT transition.
REQ-018 cpu_hold SHALL equal !run_mode, both registered from state.
REQ-019 When boot_req arrives in ST_RUN or ST_DRAIN it SHALL be ignored.
REQ-020 When the final escape byte and a CPU TX load occur in the same cycle, both SHALL complete, and the CPU byte SHALL drain in ST_BOOT.

Reset
REQ-021 When rst=0 at a clock edge (independent of clk_en), the block SHALL reset to:
- state=ST_BOOT, run_mode=0, cpu_hold=1.
- tx_valid_q=0, tx_q=8'h00, esc_cnt=0.
- last_grant=CPU, so BIOS wins the first contention.
REQ-022 Reset mid-transfer SHALL discard tx_q contents without any handshake.

Structure
REQ-023 The state enum, the grant enum (GNT_BIOS, GNT_CPU) and the ESC_CHAR default SHALL live in the shared types package alongside the ASCII constants.
REQ-024 The TX register plus round-robin logic SHALL be one sub-module, bios_tx_rr_mux; RX routing and the FSM SHALL stay in the top level.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Reset then uart_rx 'n','o','p' with bios_rx_ready=1 -> three bytes on bios_rx; cpu_rx_valid stays 0; cpu_hold=1.
- BIOS sends 'B' plus boot_req while uart_tx_ready=0 for 4 cycles -> state held in ST_DRAIN until 'B' is accepted, then run_mode=1 and cpu_hold=0 one cycle later.
- ST_RUN with bios_tx_valid and cpu_tx_valid both high and uart_tx_ready=1 -> uart_tx alternates BIOS/CPU/BIOS/CPU at 1 byte/cycle.
- ST_RUN, rx 8'h1B,8'h1B,8'h41,8'h1B,8'h1B,8'h1B -> all six forwarded to the CPU, ST_BOOT entered after the sixth, cpu_hold=1.
- clk_en toggled 1/0 during streaming -> no handshake completes in clk_en=0 cycles and byte order is preserved.
- rst=0 while tx_valid_q=1 -> uart_tx_valid=0 next cycle and reset values hold.
